// File: rtl/pc_vector_unit.sv
// Fetch-stage program counter with exception and vectored multi-line IRQ redirection.
// Optional build macro PC_ALIGN_CHECK_EN traps misaligned pcin loads as exceptions.
module pc_vector_unit #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned NIRQ       = 4,
    parameter logic [31:0] RESET_VEC  = 32'h8000_0000,
    parameter logic [31:0] EXC_VEC    = 32'h8000_0004,
    parameter logic [31:0] IRQ_BASE   = 32'h8000_0008,
    parameter int unsigned IRQ_STRIDE = 4,
    parameter int unsigned CW         = $clog2(NIRQ + 2)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             exception,
    input  logic [NIRQ-1:0]  irq,
    input  logic [NIRQ-1:0]  irq_mask,
    input  logic [WIDTH-1:0] pcin,
    output logic [WIDTH-1:0] ia,
    output logic [WIDTH-1:0] xp,
    output logic             trap_valid,
    output logic [CW-1:0]    trap_cause,
    output logic [NIRQ-1:0]  irq_ack
);

    localparam int unsigned IW = (NIRQ > 1) ? $clog2(NIRQ) : 1;

    localparam logic [WIDTH-1:0] RstAddr  = WIDTH'(RESET_VEC);
    localparam logic [WIDTH-1:0] ExcAddr  = WIDTH'(EXC_VEC);
    localparam logic [WIDTH-1:0] IrqAddr  = WIDTH'(IRQ_BASE);
    localparam logic [WIDTH-1:0] IrqStep  = WIDTH'(IRQ_STRIDE);
    localparam logic [WIDTH-1:0] InstSize = WIDTH'(4);

    logic [WIDTH-1:0] ia_q, ia_d;
    logic [WIDTH-1:0] xp_q, xp_d;
    logic [NIRQ-1:0]  pending_q, pending_d;
    logic             trap_valid_q, trap_valid_d;
    logic [CW-1:0]    trap_cause_q, trap_cause_d;
    logic [NIRQ-1:0]  irq_ack_q, irq_ack_d;

    logic [NIRQ-1:0]  eligible;
    logic             win_found;
    logic [IW-1:0]    win_idx;
    logic             user_mode;
    logic             take_irq;
    logic [WIDTH-1:0] irq_target;
    logic [WIDTH-1:0] ret_addr;
    logic             misaligned;

    assign eligible  = pending_q & ~irq_mask;
    assign user_mode = ~ia_q[WIDTH-1];
    assign ret_addr  = ia_q + InstSize;

    // Scan downward so the last hit, i.e. the lowest eligible index, wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = int'(NIRQ) - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_found = 1'b1;
                win_idx   = IW'(i);
            end
        end
    end

    assign take_irq   = win_found & user_mode & ~stall;
    assign irq_target = IrqAddr + (WIDTH'(win_idx) * IrqStep);

`ifdef PC_ALIGN_CHECK_EN
    assign misaligned = (pcin[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        ia_d         = ia_q;
        xp_d         = xp_q;
        trap_valid_d = 1'b0;
        trap_cause_d = trap_cause_q;
        irq_ack_d    = '0;

        if (take_irq) begin
            ia_d         = irq_target;
            xp_d         = ret_addr;
            trap_valid_d = 1'b1;
            trap_cause_d = CW'(win_idx) + CW'(2);
            irq_ack_d    = NIRQ'(1) << win_idx;
        end else if (exception) begin
            ia_d         = ExcAddr;
            xp_d         = ret_addr;
            trap_valid_d = 1'b1;
            trap_cause_d = CW'(1);
        end else if (stall) begin
            ia_d = ia_q;
            xp_d = xp_q;
        end else if (misaligned) begin
            // The faulting target is what software needs to see, not ia+4.
            ia_d         = ExcAddr;
            xp_d         = pcin;
            trap_valid_d = 1'b1;
            trap_cause_d = CW'(1);
        end else begin
            ia_d = pcin;
        end
    end

    // Clear wins over a same-cycle set; a still-high line re-latches next clock.
    assign pending_d = (pending_q | irq) & ~irq_ack_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ia_q         <= RstAddr;
            xp_q         <= '0;
            pending_q    <= '0;
            trap_valid_q <= 1'b0;
            trap_cause_q <= '0;
            irq_ack_q    <= '0;
        end else begin
            ia_q         <= ia_d;
            xp_q         <= xp_d;
            pending_q    <= pending_d;
            trap_valid_q <= trap_valid_d;
            trap_cause_q <= trap_cause_d;
            irq_ack_q    <= irq_ack_d;
        end
    end

    assign ia         = ia_q;
    assign xp         = xp_q;
    assign trap_valid = trap_valid_q;
    assign trap_cause = trap_cause_q;
    assign irq_ack    = irq_ack_q;

endmodule

// File: tb/tb_pc_vector_unit.sv
// Directed and random bench for pc_vector_unit against a cycle-level behavioural model.
module tb_pc_vector_unit;

    localparam logic [31:0] RV  = 32'h8000_0000;
    localparam logic [31:0] EV  = 32'h8000_0004;
    localparam logic [31:0] IB  = 32'h8000_0008;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        exception;
    logic [3:0]  irq;
    logic [3:0]  irq_mask;
    logic [31:0] pcin;
    logic [31:0] ia;
    logic [31:0] xp;
    logic        trap_valid;
    logic [2:0]  trap_cause;
    logic [3:0]  irq_ack;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] m_ia, m_xp;
    bit          m_pend [4];
    logic        m_tv;
    logic [2:0]  m_cause;
    logic [3:0]  m_ack;

    pc_vector_unit dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .exception  (exception),
        .irq        (irq),
        .irq_mask   (irq_mask),
        .pcin       (pcin),
        .ia         (ia),
        .xp         (xp),
        .trap_valid (trap_valid),
        .trap_cause (trap_cause),
        .irq_ack    (irq_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ia = RV; m_xp = 32'h0; m_tv = 1'b0; m_cause = 3'd0; m_ack = 4'd0;
        for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ia"}, ia, m_ia);
        chk({tag, ".xp"}, xp, m_xp);
        chk({tag, ".tv"}, {31'd0, trap_valid}, {31'd0, m_tv});
        chk({tag, ".cause"}, {29'd0, trap_cause}, {29'd0, m_cause});
        chk({tag, ".ack"}, {28'd0, irq_ack}, {28'd0, m_ack});
    endtask

    // One clock: drive inputs, advance the model by the priority rules, compare after the edge.
    task automatic step(input string tag, input logic st, input logic ex,
                        input logic [3:0] rq, input logic [3:0] mk, input logic [31:0] pc);
        int win;
        stall = st; exception = ex; irq = rq; irq_mask = mk; pcin = pc;
        win = -1;
        for (int i = 3; i >= 0; i--) if (m_pend[i] && !mk[i]) win = i;
        m_tv = 1'b0; m_ack = 4'd0;
        if (win >= 0 && m_ia < 32'h8000_0000 && !st) begin
            m_xp = m_ia + 32'd4;
            m_ia = IB + 32'(win) * 32'd4;
            m_tv = 1'b1; m_cause = 3'(win + 2);
            m_ack[win] = 1'b1;
        end else if (ex) begin
            m_xp = m_ia + 32'd4; m_ia = EV; m_tv = 1'b1; m_cause = 3'd1;
        end else if (st) begin
            // hold
`ifdef PC_ALIGN_CHECK_EN
        end else if (pc % 4 != 0) begin
            m_xp = pc; m_ia = EV; m_tv = 1'b1; m_cause = 3'd1;
`endif
        end else begin
            m_ia = pc;
        end
        for (int i = 0; i < 4; i++) m_pend[i] = (m_pend[i] || rq[i]) && !m_ack[i];
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; exception = 1'b0; irq = 4'd0; irq_mask = 4'd0;
        pcin = 32'h0;
        model_reset();
        #12;
        check_all("reset");
        reset = 1'b0;

        // Latch IRQ1/IRQ2 while in supervisor mode, then take IRQ1 from user ia=0x40
        step("ld40", 0, 0, 4'b0110, 4'b0000, 32'h0000_0040);
        step("irq1", 0, 0, 4'b0000, 4'b0000, 32'h0000_0044);
        chk("irq1.ia_const", ia, 32'h8000_000C);
        chk("irq1.xp_const", xp, 32'h0000_0044);
        step("ld100", 0, 0, 4'b0000, 4'b0000, 32'h0000_0100);
        step("irq2", 0, 0, 4'b0000, 4'b0000, 32'h0000_0104);
        chk("irq2.ia_const", ia, 32'h8000_0010);

        // Supervisor: a one-cycle pulse on irq[0] is retained until user mode
        step("sup", 0, 0, 4'b0001, 4'b0000, 32'h8000_0100);
        step("ld200", 0, 0, 4'b0000, 4'b0000, 32'h0000_0200);
        step("irq0", 0, 0, 4'b0000, 4'b0000, 32'h0000_0204);
        chk("irq0.ia_const", ia, 32'h8000_0008);

        // Stall holds ia with irq[3] high; release takes IRQ3
        step("ld300", 0, 0, 4'b0000, 4'b0000, 32'h0000_0300);
        for (int i = 0; i < 3; i++) step("stall", 1, 0, 4'b1000, 4'b0000, 32'h0000_0400);
        chk("stall.hold", ia, 32'h0000_0300);
        step("irq3", 0, 0, 4'b0000, 4'b0000, 32'h0000_0304);
        chk("irq3.ia_const", ia, 32'h8000_0014);
        step("stexc", 1, 1, 4'b0000, 4'b0000, 32'h0000_0500);
        chk("stexc.ia_const", ia, 32'h8000_0004);

        // Masked IRQ1 loses to exception, taken once unmasked
        step("ld10", 0, 0, 4'b0010, 4'b0010, 32'h0000_0010);
        step("mexc", 0, 1, 4'b0000, 4'b0010, 32'h0000_0014);
        chk("mexc.xp_const", xp, 32'h0000_0014);
        chk("mexc.cause_const", {29'd0, trap_cause}, 32'd1);
        step("ld20", 0, 0, 4'b0000, 4'b0010, 32'h0000_0020);
        step("unmask", 0, 0, 4'b0000, 4'b0000, 32'h0000_0024);
        chk("unmask.ia_const", ia, 32'h8000_000C);

        // Misaligned pcin
        step("mis", 0, 0, 4'b0000, 4'b0000, 32'h0000_0102);
`ifdef PC_ALIGN_CHECK_EN
        chk("mis.ia_const", ia, 32'h8000_0004);
        chk("mis.xp_const", xp, 32'h0000_0102);
`else
        chk("mis.ia_const", ia, 32'h0000_0102);
`endif

        // Asynchronous reset mid-cycle with a pending line outstanding
        step("ld120", 0, 0, 4'b0100, 4'b0000, 32'h0000_0120);
        #2 reset = 1'b1;
        model_reset();
        #1 check_all("areset");
        #1 reset = 1'b0;
        step("postrst", 0, 0, 4'b0000, 4'b0000, 32'h0000_0130);
        step("nopend", 0, 0, 4'b0000, 4'b0000, 32'h0000_0134);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [31:0] pc;
            logic [3:0]  rq;
            pc = {($urandom_range(0, 3) == 0), 31'($urandom)};
            if ($urandom_range(0, 7) != 0) pc[1:0] = 2'b00;
            rq = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
            step("rand", ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
                 rq, 4'($urandom) & 4'($urandom), pc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
